// File: rtl/pm_responder.sv
// -----------------------------------------------------------------------------
// pm_responder
// Program-memory responder: the memory end of the sequencer's PM fetch
// interface. A valid/ready boot-loader port fills the instruction memory
// before execution. Once a program is loaded, the PS fetch port returns the
// addressed opcode one clock after the request. Whenever there is no valid
// fetch, the fetch port returns NOP_OP.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous reset, active-low
//   ps_pm_cslt in   1    fetch chip-select, active-high
//   ps_pm_wrb  in   1    1 = write request (illegal), 0 = read
//   ps_pm_add  in   AW   fetch address
//   pm_ps_op   out  OPW  fetched opcode (registered, 1-cycle latency)
//   ld_start   in   1    pulse: begin (re)loading the program from address 0
//   ld_valid   in   1    loader word valid
//   ld_data    in   OPW  loader word
//   ld_last    in   1    marks the final loader word
//   ld_ready   out  1    loader word accepted this cycle when ld_valid is set
//   ld_done    out  1    program loaded; PS fetches are serviced
//   pm_busy    out  1    load in progress
//   pm_err     out  1    sticky error flag (overflow / bad fetch)
// -----------------------------------------------------------------------------
module pm_responder #(
    parameter int              PM_DEPTH = 256,
    parameter int              AW       = 16,
    parameter int              OPW      = 32,
    parameter logic [OPW-1:0]  NOP_OP   = {OPW{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps_pm_cslt,
    input  logic           ps_pm_wrb,
    input  logic [AW-1:0]  ps_pm_add,
    output logic [OPW-1:0] pm_ps_op,
    input  logic           ld_start,
    input  logic           ld_valid,
    input  logic [OPW-1:0] ld_data,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           ld_done,
    output logic           pm_busy,
    output logic           pm_err
);

    localparam int PW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;
    // One extra bit so the range compare is exact even when PM_DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(PM_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(PM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic            ld_ready_r;
    logic            ld_done_r;
    logic            pm_busy_r;
    logic            pm_err_r;
    logic [OPW-1:0]  pm_ps_op_r;

    // The memory is deliberately not reset, so a loaded program survives rst.
    logic [OPW-1:0]  mem_r [PM_DEPTH];

    logic            accept_s;
    logic            at_end_s;
    logic            in_range_s;
    logic [PW-1:0]   rd_idx_s;
    logic [OPW-1:0]  fetch_op_s;
    logic            fetch_err_s;

    assign accept_s   = (state_r == ST_LOAD) && ld_valid && ld_ready_r;
    assign at_end_s   = (ptr_r == LAST_PTR);
    assign in_range_s = ({1'b0, ps_pm_add} < DEPTH_W);
    assign rd_idx_s   = ps_pm_add[PW-1:0];

    // Fetch decode: only RUN services fetches. IDLE and LOAD return NOP without raising an error.
    always_comb begin
        fetch_op_s  = NOP_OP;
        fetch_err_s = 1'b0;
        if ((state_r == ST_RUN) && ps_pm_cslt) begin
            if (ps_pm_wrb) begin
                fetch_err_s = 1'b1;
            end else if (!in_range_s) begin
                fetch_err_s = 1'b1;
            end else begin
                fetch_op_s = mem_r[rd_idx_s];
            end
        end else begin
            fetch_op_s  = NOP_OP;
            fetch_err_s = 1'b0;
        end
    end

    // Loader write port into the instruction memory.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[ptr_r] <= ld_data;
        end
    end

    // Fetch output register: refreshed every clock, so an opcode is never held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_ps_op_r <= NOP_OP;
        end else begin
            pm_ps_op_r <= fetch_op_s;
        end
    end

    // Load/run sequencing FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {PW{1'b0}};
            ld_ready_r <= 1'b0;
            ld_done_r  <= 1'b0;
            pm_busy_r  <= 1'b0;
            pm_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_start) begin
                        state_r    <= ST_LOAD;
                        ptr_r      <= {PW{1'b0}};
                        ld_ready_r <= 1'b1;
                        ld_done_r  <= 1'b0;
                        pm_busy_r  <= 1'b1;
                        pm_err_r   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // ld_start is ignored here; only accepted words advance the load.
                    if (accept_s) begin
                        ptr_r <= ptr_r + PW'(1);
                        if (ld_last || at_end_s) begin
                            state_r    <= ST_RUN;
                            ld_ready_r <= 1'b0;
                            pm_busy_r  <= 1'b0;
                            ld_done_r  <= 1'b1;
                            // Filling the last slot without ld_last is an overflow.
                            if (!ld_last) begin
                                pm_err_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    // Reload clears the error; this takes priority over a same-cycle fetch error.
                    if (ld_start) begin
                        state_r    <= ST_LOAD;
                        ptr_r      <= {PW{1'b0}};
                        ld_ready_r <= 1'b1;
                        ld_done_r  <= 1'b0;
                        pm_busy_r  <= 1'b1;
                        pm_err_r   <= 1'b0;
                    end else if (fetch_err_s) begin
                        pm_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ptr_r      <= {PW{1'b0}};
                    ld_ready_r <= 1'b0;
                    ld_done_r  <= 1'b0;
                    pm_busy_r  <= 1'b0;
                    pm_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign pm_ps_op = pm_ps_op_r;
    assign ld_ready = ld_ready_r;
    assign ld_done  = ld_done_r;
    assign pm_busy  = pm_busy_r;
    assign pm_err   = pm_err_r;

endmodule

// File: tb/tb_pm_responder.sv
// -----------------------------------------------------------------------------
// tb_pm_responder
// Scoreboard bench for pm_responder. The driver applies one input vector per
// cycle and advances a behavioural model to produce the expected outputs,
// which go into a queue. A monitor pops one entry at every falling edge and
// compares it with the DUT. A second instance with PM_DEPTH=4 covers loader
// overflow.
// -----------------------------------------------------------------------------
module tb_pm_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        cslt, wrb, ld_start, ld_valid, ld_last;
    logic [15:0] add;
    logic [31:0] ld_data;
    logic [31:0] op;
    logic        ld_ready, ld_done, pm_busy, pm_err;

    logic        s_cslt, s_wrb, s_start, s_valid, s_last;
    logic [15:0] s_add;
    logic [31:0] s_data;
    logic [31:0] s_op;
    logic        s_ready, s_done, s_busy, s_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] op;
        logic        err;
        logic        done;
        logic        ready;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int          m_mode;   // 0 = idle, 1 = loading, 2 = running
    int          m_ptr;
    logic        m_done;
    logic        m_err;
    logic [31:0] m_mem [DEPTH];

    pm_responder #(.PM_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .ps_pm_cslt(cslt), .ps_pm_wrb(wrb), .ps_pm_add(add), .pm_ps_op(op),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .pm_busy(pm_busy), .pm_err(pm_err)
    );

    pm_responder #(.PM_DEPTH(4)) u_small (
        .clk(clk), .rst(rst),
        .ps_pm_cslt(s_cslt), .ps_pm_wrb(s_wrb), .ps_pm_add(s_add), .pm_ps_op(s_op),
        .ld_start(s_start), .ld_valid(s_valid), .ld_data(s_data), .ld_last(s_last),
        .ld_ready(s_ready), .ld_done(s_done), .pm_busy(s_busy), .pm_err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each falling edge shows the result of the preceding rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pm_ps_op", op, e.op);
            chk("pm_err", {31'd0, pm_err}, {31'd0, e.err});
            chk("ld_done", {31'd0, ld_done}, {31'd0, e.done});
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, e.ready});
            chk("pm_busy", {31'd0, pm_busy}, {31'd0, e.busy});
        end
    end

    // Apply one cycle of stimulus, predict the result, then wait for it to be checked.
    task automatic cycle(input logic r, input logic st, input logic cs, input logic wr,
                         input logic [15:0] a, input logic v, input logic [31:0] d,
                         input logic l);
        exp_t        e;
        logic [31:0] p;
        rst = r; ld_start = st; cslt = cs; wrb = wr; add = a;
        ld_valid = v; ld_data = d; ld_last = l;
        p = 32'h0;
        if (!r) begin
            m_mode = 0; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            // A fetch sees the mode that is in force before this edge.
            if (m_mode == 2 && cs) begin
                if (wr || int'(a) >= DEPTH) m_err = 1'b1;
                else p = m_mem[a];
            end
            if (m_mode == 1) begin
                if (v) begin
                    m_mem[m_ptr] = d;
                    if (l) begin
                        m_mode = 2; m_done = 1'b1;
                    end else if (m_ptr == DEPTH - 1) begin
                        m_mode = 2; m_done = 1'b1; m_err = 1'b1;
                    end
                    m_ptr++;
                end
            end else if (st) begin
                m_mode = 1; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;
            end
        end
        e.op = p; e.err = m_err; e.done = m_done;
        e.ready = (m_mode == 1); e.busy = (m_mode == 1);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic fetch(input logic [15:0] a, input logic wr);
        cycle(1'b1, 1'b0, 1'b1, wr, a, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic load_word(input logic [31:0] d, input logic l);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, d, l);
    endtask

    task automatic start();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
    endtask

    logic [31:0] prog [4];
    logic [31:0] sw   [5];

    initial begin
        prog[0] = 32'h4000_0001; prog[1] = 32'h0C00_1234;
        prog[2] = 32'h8000_0005; prog[3] = 32'h0000_0000;
        for (int i = 0; i < 5; i++) sw[i] = 32'hA5A5_0000 + 32'(i);
        m_mode = 0; m_ptr = 0; m_done = 1'b0; m_err = 1'b0;
        rst = 1'b0; cslt = 1'b0; wrb = 1'b0; add = 16'd0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
        s_cslt = 1'b0; s_wrb = 1'b0; s_add = 16'd0; s_start = 1'b0;
        s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
        @(negedge clk);
        #1;

        // Reset state, then fetches in IDLE return NOP without error
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
        fetch(16'd0, 1'b0);
        fetch(16'd300, 1'b0);

        // Load four words, then fetch them back
        start();
        start();   // ignored while loading
        for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
        for (int i = 0; i < 4; i++) fetch(16'(i), 1'b0);
        idle();

        // Chip-select low returns NOP and does not hold the previous opcode
        fetch(16'd1, 1'b0);
        idle();
        idle();

        // Out-of-range and write fetches: NOP and sticky error; memory unchanged
        fetch(16'd256, 1'b0);
        fetch(16'd2, 1'b1);
        idle();
        fetch(16'd2, 1'b0);
        fetch(16'hFFFF, 1'b0);
        idle();

        // Overflow on the 4-deep instance
        s_start = 1'b1; idle(); s_start = 1'b0;
        chk("small ld_ready after start", {31'd0, s_ready}, 32'd1);
        chk("small pm_busy after start", {31'd0, s_busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = sw[i];
            idle();
            chk("small ld_ready", {31'd0, s_ready}, (i < 3) ? 32'd1 : 32'd0);
            chk("small ld_done", {31'd0, s_done}, (i < 3) ? 32'd0 : 32'd1);
            chk("small pm_err", {31'd0, s_err}, (i < 3) ? 32'd0 : 32'd1);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_cslt = 1'b1; s_add = 16'(i);
            idle();
            chk("small fetch", s_op, sw[i]);
        end
        s_cslt = 1'b0;

        // Reset during a reload; fetches are NOP until a complete fresh load
        start();
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 32'h3333_3333, 1'b0);
        fetch(16'd0, 1'b0);
        fetch(16'd1, 1'b0);
        start();
        for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
        for (int i = 0; i < 4; i++) fetch(16'(i), 1'b0);

        // Reload from an error state clears the error; one-word program
        fetch(16'd400, 1'b0);
        // ld_start in RUN alongside a fetch: that fetch is still serviced
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0, 32'd0, 1'b0);
        fetch(16'd1, 1'b0);
        load_word(32'hFFFF_0000, 1'b1);
        fetch(16'd0, 1'b0);
        idle();

        // Randomised traffic; reads stay within addresses known to be written
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 65279))
                                            : 16'($urandom_range(0, 3));
            cycle(1'b1, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, a, 1'($urandom_range(0, 1)),
                  32'($urandom), $urandom_range(0, 3) == 0);
        end
        idle();

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
